mash_ratio_ctrl: RTL

MASH_RATIO_CTRL -- requirements
Module: mash_ratio_ctrl

---
 rtl/mash_ratio_ctrl.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/mash_ratio_ctrl.sv
// mash_ratio_ctrl: steps the {i,f} divide ratio driven to a MASH modulator
// toward a requested target, holds it for SETTLE_CYC cycles, then signals done.
// Optional build macro RATIO_CLAMP_EN: out-of-range requests are clamped to
// 3.0000 / 11.FFFF instead of being rejected with an err pulse.
module mash_ratio_ctrl #(
  parameter logic [19:0] STEP       = 20'h01000,
  parameter int unsigned SETTLE_CYC = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_i,
  input  logic [15:0] req_f,
  input  logic        abort,
  output logic [3:0]  mod_i,
  output logic [15:0] mod_f,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RAMP   = 2'd1,
    S_SETTLE = 2'd2
  } state_t;

  localparam logic [19:0]        RATIO_RESET = 20'h30000;
`ifdef RATIO_CLAMP_EN
  localparam logic [19:0]        RATIO_MAX   = 20'hBFFFF;
`endif
  localparam logic signed [20:0] STEP_POS    = $signed({1'b0, STEP});
  localparam logic signed [20:0] STEP_NEG    = -STEP_POS;
  localparam logic [7:0]         SETTLE_LAST = 8'(SETTLE_CYC - 1);

  state_t             state_q, state_d;
  logic [19:0]        cur_q, cur_d;
  logic [19:0]        target_q, target_d;
  logic [7:0]         cnt_q, cnt_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic [19:0]        req_ratio;
  logic               req_legal;
  logic               accept;
  logic signed [20:0] diff;

  assign req_ratio = {req_i, req_f};
  assign req_legal = (req_i >= 4'd3) && (req_i <= 4'd11);
  assign req_ready = (state_q == S_IDLE) & ~abort;
  assign accept    = req_valid & req_ready;
  // Both ratios are unsigned 20-bit, so a 21-bit signed difference never wraps.
  assign diff      = $signed({1'b0, target_q}) - $signed({1'b0, cur_q});

  // Next-state and datapath decisions for the IDLE / RAMP / SETTLE sequence.
  always_comb begin
    // NOTE: every next-state signal is given a default before the case so no
    // path leaves it unassigned; otherwise synthesis would infer latches.
    state_d  = state_q;
    cur_d    = cur_q;
    target_d = target_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    err_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (req_legal) begin
            target_d = req_ratio;
            state_d  = S_RAMP;
          end else begin
`ifdef RATIO_CLAMP_EN
            target_d = (req_i < 4'd3) ? RATIO_RESET : RATIO_MAX;
            state_d  = S_RAMP;
`else
            // Request is consumed but changes nothing except the err pulse.
            err_d = 1'b1;
`endif
          end
        end
      end

      S_RAMP: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (diff > STEP_POS) begin
          cur_d = cur_q + STEP;
        end else if (diff < STEP_NEG) begin
          cur_d = cur_q - STEP;
        end else begin
          // Within one step (including already equal): land exactly on target.
          cur_d   = target_q;
          cnt_d   = SETTLE_LAST;
          state_d = S_SETTLE;
        end
      end

      S_SETTLE: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (cnt_q == 8'd0) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset returns the modulator to ratio 3.0000.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cur_q    <= RATIO_RESET;
      target_q <= RATIO_RESET;
      cnt_q    <= 8'd0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q  <= state_d;
      cur_q    <= cur_d;
      target_q <= target_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign mod_i = cur_q[19:16];
  assign mod_f = cur_q[15:0];
  assign busy  = (state_q != S_IDLE);
  assign done  = done_q;
  assign err   = err_q;

endmodule
